clock_autoset: RTL and testbench

Automatic time/date setter for the `struct_diag` digital clock. On a start request it latches a target month, date, hour, minute and weekday. It reads the clock's seven-segment display outputs back and drives `Timeset` and the per-field advance inputs, one step at a time, until each displayed field equals its target. It sits beside `struct_diag` on the same `Clk`, in place of a human or bench pressing the advance buttons.

---
 rtl/clock_autoset.sv | 246 ++++++++++++++++++++++++
 tb/tb_clock_autoset.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_autoset.sv
// Automatic time/date setter for the struct_diag clock: reads the seven-segment
// displays back and pulses the per-field advance inputs until each field matches.
module clock_autoset #(
  parameter int NS     = 60,
  parameter int NH     = 24,
  parameter int NW     = 7,
  parameter int NM     = 12,
  parameter int SETTLE = 2,
  parameter int MAXADV = 64
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [3:0] TgtMonth,
  input  logic [4:0] TgtDate,
  input  logic [4:0] TgtHrs,
  input  logic [5:0] TgtMin,
  input  logic [2:0] TgtDay,
  input  logic [6:0] Month1disp,
  input  logic [6:0] Month0disp,
  input  logic [6:0] Date1disp,
  input  logic [6:0] Date0disp,
  input  logic [6:0] H1disp,
  input  logic [6:0] H0disp,
  input  logic [6:0] M1disp,
  input  logic [6:0] M0disp,
  input  logic [6:0] D0disp,
  output logic       Timeset,
  output logic       Monthadv,
  output logic       Dateadv,
  output logic       Hrsadv,
  output logic       Minadv,
  output logic       Dayadv,
  output logic       Busy,
  output logic       Done,
  output logic       Error
);

  typedef enum logic [2:0] {IDLE, CHECK, SETUP, CMP, ADV, WAIT, FINISH, ERR} state_t;

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [6:0] MAXADV_L = 7'(MAXADV);
  localparam logic [3:0] NM_L = 4'(NM);
  localparam logic [4:0] NH_L = 5'(NH);
  localparam logic [5:0] NS_L = 6'(NS);
  localparam logic [2:0] NW_L = 3'(NW);

  localparam logic [2:0] F_MONTH = 3'd0;
  localparam logic [2:0] F_DATE  = 3'd1;
  localparam logic [2:0] F_HRS   = 3'd2;
  localparam logic [2:0] F_MIN   = 3'd3;
  localparam logic [2:0] F_DAY   = 3'd4;

  // Bit 4 of the result flags an undecodable segment pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F, 7'h00: seg_decode = 5'h00;
      7'h06:        seg_decode = 5'h01;
      7'h5B:        seg_decode = 5'h02;
      7'h4F:        seg_decode = 5'h03;
      7'h66:        seg_decode = 5'h04;
      7'h6D:        seg_decode = 5'h05;
      7'h7D:        seg_decode = 5'h06;
      7'h07:        seg_decode = 5'h07;
      7'h7F:        seg_decode = 5'h08;
      7'h6F:        seg_decode = 5'h09;
      default:      seg_decode = 5'h10;
    endcase
  endfunction

  function automatic logic [6:0] two_digit(input logic [3:0] t, input logic [3:0] u);
    two_digit = 7'(t) * 7'd10 + 7'(u);
  endfunction

  function automatic logic [4:0] days_in(input logic [3:0] m);
    case (m)
      4'd2:                    days_in = 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: days_in = 5'd30;
      default:                 days_in = 5'd31;
    endcase
  endfunction

  state_t state_q, state_d;
  logic [2:0] field_q, field_d;
  logic [6:0] cnt_q, cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [3:0] tgt_month_q, tgt_month_d;
  logic [4:0] tgt_date_q, tgt_date_d;
  logic [4:0] tgt_hrs_q, tgt_hrs_d;
  logic [5:0] tgt_min_q, tgt_min_d;
  logic [2:0] tgt_day_q, tgt_day_d;
  logic timeset_q, timeset_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [4:0] adv_q, adv_d;

  logic [4:0] d_mo1, d_mo0, d_da1, d_da0, d_h1, d_h0, d_m1, d_m0, d_d0;
  logic bad, tgt_ok;
  logic [6:0] month_val, date_val, hrs_val, min_val, day_val, cur_val, cur_tgt;

  assign d_mo1 = seg_decode(Month1disp);
  assign d_mo0 = seg_decode(Month0disp);
  assign d_da1 = seg_decode(Date1disp);
  assign d_da0 = seg_decode(Date0disp);
  assign d_h1  = seg_decode(H1disp);
  assign d_h0  = seg_decode(H0disp);
  assign d_m1  = seg_decode(M1disp);
  assign d_m0  = seg_decode(M0disp);
  assign d_d0  = seg_decode(D0disp);

  assign bad = d_mo1[4] | d_mo0[4] | d_da1[4] | d_da0[4] | d_h1[4] | d_h0[4] |
               d_m1[4] | d_m0[4] | d_d0[4];

  assign month_val = two_digit(d_mo1[3:0], d_mo0[3:0]);
  assign date_val  = two_digit(d_da1[3:0], d_da0[3:0]);
  assign hrs_val   = two_digit(d_h1[3:0], d_h0[3:0]);
  assign min_val   = two_digit(d_m1[3:0], d_m0[3:0]);
  assign day_val   = {3'b000, d_d0[3:0]};

  // Date range depends on the latched month, so an impossible date like Feb 30 is rejected.
  assign tgt_ok = (tgt_month_q >= 4'd1) && (tgt_month_q <= NM_L) &&
                  (tgt_date_q >= 5'd1) && (tgt_date_q <= days_in(tgt_month_q)) &&
                  (tgt_hrs_q < NH_L) && (tgt_min_q < NS_L) && (tgt_day_q < NW_L);

  always_comb begin
    cur_val = month_val;
    cur_tgt = {3'b000, tgt_month_q};
    case (field_q)
      F_DATE: begin cur_val = date_val; cur_tgt = {2'b00, tgt_date_q}; end
      F_HRS:  begin cur_val = hrs_val;  cur_tgt = {2'b00, tgt_hrs_q};  end
      F_MIN:  begin cur_val = min_val;  cur_tgt = {1'b0, tgt_min_q};   end
      F_DAY:  begin cur_val = day_val;  cur_tgt = {4'b0000, tgt_day_q}; end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    field_d     = field_q;
    cnt_d       = cnt_q;
    settle_d    = settle_q;
    tgt_month_d = tgt_month_q;
    tgt_date_d  = tgt_date_q;
    tgt_hrs_d   = tgt_hrs_q;
    tgt_min_d   = tgt_min_q;
    tgt_day_d   = tgt_day_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          tgt_month_d = TgtMonth;
          tgt_date_d  = TgtDate;
          tgt_hrs_d   = TgtHrs;
          tgt_min_d   = TgtMin;
          tgt_day_d   = TgtDay;
          state_d     = CHECK;
        end
      end
      CHECK: state_d = tgt_ok ? SETUP : ERR;
      SETUP: begin
        field_d = F_MONTH;
        cnt_d   = '0;
        state_d = CMP;
      end
      CMP: begin
        if (bad) begin
          state_d = ERR;
        end else if (cur_val == cur_tgt) begin
          if (field_q == F_DAY) begin
            state_d = FINISH;
          end else begin
            field_d = field_q + 3'd1;
            cnt_d   = '0;
          end
        end else if (cnt_q == MAXADV_L) begin
          state_d = ERR;
        end else begin
          state_d = ADV;
        end
      end
      ADV: begin
        cnt_d    = cnt_q + 7'd1;
        settle_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (settle_q == SETTLE_LAST) state_d = CMP;
        else settle_d = settle_q + SW'(1);
      end
      FINISH: state_d = IDLE;
      ERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered; most follow the state being entered so they line up with it.
    busy_d    = state_d inside {CHECK, SETUP, CMP, ADV, WAIT};
    timeset_d = state_d inside {CMP, ADV, WAIT};
    adv_d     = '0;
    if (state_d == ADV) adv_d[field_d] = 1'b1;
    done_d    = (state_q == FINISH);
    error_d   = (state_d == ERR);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      field_q     <= '0;
      cnt_q       <= '0;
      settle_q    <= '0;
      tgt_month_q <= '0;
      tgt_date_q  <= '0;
      tgt_hrs_q   <= '0;
      tgt_min_q   <= '0;
      tgt_day_q   <= '0;
      timeset_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      adv_q       <= '0;
    end else begin
      state_q     <= state_d;
      field_q     <= field_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      tgt_month_q <= tgt_month_d;
      tgt_date_q  <= tgt_date_d;
      tgt_hrs_q   <= tgt_hrs_d;
      tgt_min_q   <= tgt_min_d;
      tgt_day_q   <= tgt_day_d;
      timeset_q   <= timeset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      adv_q       <= adv_d;
    end
  end

  assign Timeset  = timeset_q;
  assign Monthadv = adv_q[0];
  assign Dateadv  = adv_q[1];
  assign Hrsadv   = adv_q[2];
  assign Minadv   = adv_q[3];
  assign Dayadv   = adv_q[4];
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Error    = error_q;

endmodule

// File: tb/tb_clock_autoset.sv
// Bench for clock_autoset: a behavioural struct_diag display model plus a timing
// model of the setter built from step counts, checked on every negative clock edge.
module tb_clock_autoset;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   logic Start = 1'b0;
   logic [3:0] TgtMonth = '0;
   logic [4:0] TgtDate = '0;
   logic [4:0] TgtHrs = '0;
   logic [5:0] TgtMin = '0;
   logic [2:0] TgtDay = '0;
   logic [6:0] Month1disp, Month0disp, Date1disp, Date0disp, H1disp, H0disp;
   logic [6:0] M1disp, M0disp, D0disp;
   logic Timeset, Monthadv, Dateadv, Hrsadv, Minadv, Dayadv, Busy, Done, Error;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;

   // Clock-display model state (what struct_diag would be showing)
   int mMon = 1, mDate = 1, mHrs = 0, mMin = 0, mDay = 0;
   int ldMon = 1, ldDate = 1, ldHrs = 0, ldMin = 0, ldDay = 0;
   logic modelLoad = 1'b0;
   logic ignoreHrs = 1'b0;
   logic forceBad = 1'b0;

   // Timing-model context for the run in progress
   int tmode = 0;
   int k = 0;
   int stepsTotal = 0;
   int lastSt[5];

   // Observed pulse statistics
   int nAdv[5] = '{0, 0, 0, 0, 0};
   int nDone = 0, nErr = 0, lastDoneCyc = -1, lastErrCyc = -1;

   logic [4:0] advVec;
   assign advVec = {Dayadv, Minadv, Hrsadv, Dateadv, Monthadv};

   clock_autoset dut (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
      .TgtMonth(TgtMonth), .TgtDate(TgtDate), .TgtHrs(TgtHrs), .TgtMin(TgtMin), .TgtDay(TgtDay),
      .Month1disp(Month1disp), .Month0disp(Month0disp), .Date1disp(Date1disp), .Date0disp(Date0disp),
      .H1disp(H1disp), .H0disp(H0disp), .M1disp(M1disp), .M0disp(M0disp), .D0disp(D0disp),
      .Timeset(Timeset), .Monthadv(Monthadv), .Dateadv(Dateadv), .Hrsadv(Hrsadv),
      .Minadv(Minadv), .Dayadv(Dayadv), .Busy(Busy), .Done(Done), .Error(Error)
   );

   // Free-running 10-unit clock
   always #5 Clk = ~Clk;

   // Edge counter: at a negedge, cyc == n means "after edge n"
   always @(posedge Clk) cyc <= cyc + 1;

   function automatic logic [6:0] seg7(input int d);
      case (d)
         0: seg7 = 7'h3F;
         1: seg7 = 7'h06;
         2: seg7 = 7'h5B;
         3: seg7 = 7'h4F;
         4: seg7 = 7'h66;
         5: seg7 = 7'h6D;
         6: seg7 = 7'h7D;
         7: seg7 = 7'h07;
         8: seg7 = 7'h7F;
         default: seg7 = 7'h6F;
      endcase
   endfunction

   function automatic int dim(input int m);
      case (m)
         2: dim = 28;
         4, 6, 9, 11: dim = 30;
         default: dim = 31;
      endcase
   endfunction

   // Display encoding; a zero month tens digit is shown blank
   assign Month1disp = ((mMon / 10) == 0) ? 7'h00 : seg7(mMon / 10);
   assign Month0disp = seg7(mMon % 10);
   assign Date1disp  = seg7(mDate / 10);
   assign Date0disp  = seg7(mDate % 10);
   assign H1disp     = seg7(mHrs / 10);
   assign H0disp     = seg7(mHrs % 10);
   assign M1disp     = seg7(mMin / 10);
   assign M0disp     = forceBad ? 7'h55 : seg7(mMin % 10);
   assign D0disp     = seg7(mDay);

   // struct_diag behaviour: in set mode each advance bumps one field with wrap, no carry
   always @(posedge Clk) begin
      if (modelLoad) begin
         mMon <= ldMon; mDate <= ldDate; mHrs <= ldHrs; mMin <= ldMin; mDay <= ldDay;
      end else if (Timeset) begin
         if (Monthadv) mMon <= (mMon == 12) ? 1 : mMon + 1;
         if (Dateadv) mDate <= (mDate >= dim(mMon)) ? 1 : mDate + 1;
         if (Hrsadv && !ignoreHrs) mHrs <= (mHrs == 23) ? 0 : mHrs + 1;
         if (Minadv) mMin <= (mMin == 59) ? 0 : mMin + 1;
         if (Dayadv) mDay <= (mDay == 6) ? 0 : mDay + 1;
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle compare: pulse bookkeeping, invariants, and the run timing model
   always @(negedge Clk) begin
      for (int i = 0; i < 5; i++) if (advVec[i]) nAdv[i]++;
      if (Done) begin nDone++; lastDoneCyc = cyc; end
      if (Error) begin nErr++; lastErrCyc = cyc; end
      checkOutput("adv_at_most_one", int'($countones(advVec) <= 1), 1);
      checkOutput("done_error_exclusive", int'(Done && Error), 0);
      checkOutput("adv_implies_timeset", int'((|advVec) && !Timeset), 0);
      if (tmode == 1 && cyc >= k && cyc <= k + 8 + 4 * stepsTotal) begin
         checkOutput("run_busy", int'(Busy), int'(cyc <= k + 6 + 4 * stepsTotal));
         checkOutput("run_timeset", int'(Timeset),
                     int'(cyc >= k + 2 && cyc <= k + 6 + 4 * stepsTotal));
         checkOutput("run_done", int'(Done), int'(cyc == k + 8 + 4 * stepsTotal));
         checkOutput("run_error", int'(Error), 0);
      end
      if (tmode == 2 && cyc >= k && cyc <= k + 3) begin
         checkOutput("inv_busy", int'(Busy), int'(cyc == k));
         checkOutput("inv_timeset", int'(Timeset), 0);
         checkOutput("inv_error", int'(Error), int'(cyc == k + 1));
         checkOutput("inv_done", int'(Done), 0);
      end
   end

   task automatic loadModel(input int mo, input int da, input int h, input int mi, input int dy);
      @(negedge Clk);
      ldMon = mo; ldDate = da; ldHrs = h; ldMin = mi; ldDay = dy;
      modelLoad = 1'b1;
      @(posedge Clk);
      #1 modelLoad = 1'b0;
   endtask

   // Present targets with Start for one sampling edge; k records that edge
   task automatic applyStimulus(input int mo, input int da, input int h, input int mi, input int dy);
      @(negedge Clk);
      TgtMonth = 4'(mo); TgtDate = 5'(da); TgtHrs = 5'(h); TgtMin = 6'(mi); TgtDay = 3'(dy);
      Start = 1'b1;
      @(posedge Clk);
      #1;
      k = cyc;
      Start = 1'b0;
   endtask

   // Valid run: step counts come from modular distances on the display model
   task automatic runValid(input int mo, input int da, input int h, input int mi, input int dy,
                           input int poke);
      int base[5];
      int baseDone, baseErr;
      lastSt[0] = (mo - mMon + 12) % 12;
      lastSt[1] = (da - mDate + dim(mo)) % dim(mo);
      lastSt[2] = (h - mHrs + 24) % 24;
      lastSt[3] = (mi - mMin + 60) % 60;
      lastSt[4] = (dy - mDay + 7) % 7;
      stepsTotal = lastSt[0] + lastSt[1] + lastSt[2] + lastSt[3] + lastSt[4];
      for (int i = 0; i < 5; i++) base[i] = nAdv[i];
      baseDone = nDone;
      baseErr = nErr;
      applyStimulus(mo, da, h, mi, dy);
      tmode = 1;
      while (cyc < k + 4 * stepsTotal + 10) begin
         @(negedge Clk);
         if (poke > 0 && cyc == k + poke) begin
            Start = 1'b1; TgtMonth = 4'd1; TgtDate = 5'd1; TgtHrs = 5'd0; TgtMin = 6'd0; TgtDay = 3'd0;
         end else begin
            Start = 1'b0;
         end
      end
      tmode = 0;
      for (int i = 0; i < 5; i++) checkOutput($sformatf("adv_pulses_f%0d", i), nAdv[i] - base[i], lastSt[i]);
      checkOutput("done_count", nDone - baseDone, 1);
      checkOutput("error_count", nErr - baseErr, 0);
      checkOutput("done_latency", lastDoneCyc - k, 8 + 4 * stepsTotal);
      checkOutput("disp_month", mMon, mo);
      checkOutput("disp_date", mDate, da);
      checkOutput("disp_hrs", mHrs, h);
      checkOutput("disp_min", mMin, mi);
      checkOutput("disp_day", mDay, dy);
      checkOutput("timeset_after", int'(Timeset), 0);
   endtask

   task automatic checkAllLow(input string name);
      checkOutput(name, int'({Timeset, advVec, Busy, Done, Error}), 0);
   endtask

   int invMon[8]  = '{2, 1, 0, 13, 1, 1, 1, 4};
   int invDate[8] = '{30, 1, 1, 1, 0, 1, 1, 31};
   int invHrs[8]  = '{0, 24, 0, 0, 0, 0, 0, 0};
   int invMin[8]  = '{0, 0, 0, 0, 0, 60, 0, 0};
   int invDay[8]  = '{0, 0, 0, 0, 0, 0, 7, 0};
   int litSteps[5] = '{11, 30, 23, 59, 6};

   // Directed sequence
   initial begin
      int w, bErr, bDone, bHrs, bAdvAll;

      @(negedge Clk);
      checkAllLow("reset_outputs");
      @(negedge Clk);
      Reset_n = 1'b1;
      loadModel(1, 1, 0, 0, 0);

      $display("[TB] reset during an advance pulse");
      applyStimulus(2, 1, 0, 0, 0);
      w = 0;
      while (!Monthadv && w < 30) begin @(negedge Clk); w++; end
      checkOutput("reach_month_adv", int'(Monthadv), 1);
      #1 Reset_n = 1'b0;
      #1 checkAllLow("async_reset_outputs");
      repeat (2) begin @(negedge Clk); checkAllLow("held_reset_outputs"); end
      Reset_n = 1'b1;
      repeat (4) begin @(negedge Clk); checkAllLow("idle_after_reset"); end
      checkOutput("month_not_advanced", mMon, 1);
      loadModel(1, 1, 0, 0, 0);

      $display("[TB] full sweep to Dec 31 23:59 day 6");
      runValid(12, 31, 23, 59, 6, 0);
      checkOutput("sweep_total_steps", stepsTotal, 129);
      for (int i = 0; i < 5; i++) checkOutput($sformatf("sweep_steps_f%0d", i), lastSt[i], litSteps[i]);
      checkOutput("sweep_done_latency", lastDoneCyc - k, 524);

      $display("[TB] target already displayed");
      runValid(12, 31, 23, 59, 6, 0);
      checkOutput("equal_done_latency", lastDoneCyc - k, 8);

      $display("[TB] wrap to Mar 15 08:30 day 2");
      runValid(3, 15, 8, 30, 2, 0);
      checkOutput("wrap_total_steps", stepsTotal, 61);

      $display("[TB] out-of-range targets");
      for (int i = 0; i < 8; i++) begin
         bErr = nErr; bDone = nDone;
         bAdvAll = nAdv[0] + nAdv[1] + nAdv[2] + nAdv[3] + nAdv[4];
         applyStimulus(invMon[i], invDate[i], invHrs[i], invMin[i], invDay[i]);
         tmode = 2;
         repeat (5) @(negedge Clk);
         tmode = 0;
         checkOutput($sformatf("inv%0d_error_count", i), nErr - bErr, 1);
         checkOutput($sformatf("inv%0d_error_latency", i), lastErrCyc - k, 1);
         checkOutput($sformatf("inv%0d_done_count", i), nDone - bDone, 0);
         checkOutput($sformatf("inv%0d_no_adv", i),
                     nAdv[0] + nAdv[1] + nAdv[2] + nAdv[3] + nAdv[4] - bAdvAll, 0);
      end

      $display("[TB] bad segment pattern during minute compare");
      bDone = nDone;
      applyStimulus(3, 15, 8, 30, 2);
      repeat (5) begin @(posedge Clk); #1; end
      forceBad = 1'b1;
      @(negedge Clk);
      checkOutput("bad_timeset_before", int'(Timeset), 1);
      checkOutput("bad_error_before", int'(Error), 0);
      @(posedge Clk);
      #1 forceBad = 1'b0;
      checkOutput("bad_error", int'(Error), 1);
      checkOutput("bad_timeset_after", int'(Timeset), 0);
      checkOutput("bad_minadv_after", int'(Minadv), 0);
      checkOutput("bad_busy_after", int'(Busy), 0);
      repeat (3) @(negedge Clk);
      checkOutput("bad_no_done", nDone - bDone, 0);

      $display("[TB] Start while busy is ignored");
      runValid(3, 15, 8, 31, 2, 3);

      $display("[TB] advance limit on a stuck hour field");
      ignoreHrs = 1'b1;
      bErr = nErr; bDone = nDone; bHrs = nAdv[2];
      applyStimulus(3, 15, 9, 31, 2);
      repeat (300) @(negedge Clk);
      ignoreHrs = 1'b0;
      checkOutput("stuck_hrs_pulses", nAdv[2] - bHrs, 64);
      checkOutput("stuck_error_count", nErr - bErr, 1);
      checkOutput("stuck_error_latency", lastErrCyc - k, 261);
      checkOutput("stuck_no_done", nDone - bDone, 0);
      checkOutput("stuck_hrs_display", mHrs, 8);
      checkAllLow("stuck_idle_after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
